// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fullsubtractor1.sv
// One-bit full subtractor: x - y - bi, producing difference d and borrow-out bo.
module fullsubtractor1 (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin LSB first, one bit per clock,
// reporting the difference, unsigned borrow-out and signed overflow.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, next_state;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic             d_bit, bo_bit;
    logic             last;

    assign last = (cnt == CW'(WIDTH - 1));

    fullsubtractor1 u_fs (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .bi (borrow),
        .d  (d_bit),
        .bo (bo_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last)  next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT) || (state == DONE);
        done = (state == DONE);
    end

    // Counter saturates on the last bit so it never wraps within an operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            d      <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sr   <= a;
                    b_sr   <= b;
                    borrow <= bin;
                    cnt    <= '0;
                    d      <= '0;
                    bout   <= 1'b0;
                    ovf    <= 1'b0;
                end
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    borrow <= bo_bit;
                    d      <= {d_bit, d[WIDTH-1:1]};
                    cnt    <= last ? cnt : cnt + CW'(1);
                    if (last) begin
                        // borrow here is the borrow into the MSB
                        bout <= bo_bit;
                        ovf  <= borrow ^ bo_bit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8) with a result scoreboard.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] d;
        logic       bout;
        logic       ovf;
    } exp_t;

    logic       clk, rst, start, bin;
    logic [7:0] a, b;
    logic       busy, done, bout, ovf;
    logic [7:0] d;

    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   done_cyc[$];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic bi);
        exp_t e;
        int   ux, uy, sx, sy, r;
        ux = int'(x);
        uy = int'(y);
        sx = x[7] ? ux - 256 : ux;
        sy = y[7] ? uy - 256 : uy;
        r  = sx - sy - int'(bi);
        e.d    = 8'(ux - uy - int'(bi));
        e.bout = (ux < uy + int'(bi));
        e.ovf  = (r > 127) || (r < -128);
        return e;
    endfunction

    // Scoreboard: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            done_cyc.push_back(cyc);
            checks++;
            assert (sb.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_done: observed done with empty scoreboard, expected none");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_d", 32'(d), 32'(e.d));
                check("sb_bout", 32'(bout), 32'(e.bout));
                check("sb_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    task automatic run_op(input logic [7:0] oa, input logic [7:0] ob, input logic obi);
        int   n;
        exp_t e;
        e = model(oa, ob, obi);
        @(negedge clk);
        a = oa; b = ob; bin = obi; start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        n = 1;
        check("busy_after_accept", 32'(busy), 1);
        check("d_cleared_on_accept", 32'(d), 0);
        while (!done && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", n, 9);
        @(posedge clk);
        #1;
        check("idle_after_done", 32'(busy), 0);
        check("hold_d", 32'(d), 32'(e.d));
        check("hold_bout", 32'(bout), 32'(e.bout));
        check("hold_ovf", 32'(ovf), 32'(e.ovf));
    endtask

    initial begin
        int   base;
        exp_t e;
        rst = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_d", 32'(d), 0);
        check("rst_bout", 32'(bout), 0);
        check("rst_ovf", 32'(ovf), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // arithmetic corners
        run_op(8'h05, 8'h03, 1'b0);
        run_op(8'h03, 8'h05, 1'b0);
        run_op(8'h00, 8'h00, 1'b1);
        run_op(8'h80, 8'h01, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1);
        run_op(8'h00, 8'hFF, 1'b0);
        for (int i = 0; i < 4; i++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom));

        // start pulses during SHIFT and DONE are ignored
        e = model(8'h3C, 8'h1A, 1'b1);
        @(negedge clk);
        a = 8'h3C; b = 8'h1A; bin = 1'b1; start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        base = done_cnt;
        repeat (3) @(posedge clk);
        #1 a = 8'hAA; b = 8'h55; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("done_in_done_state", 32'(done), 1);
        a = 8'h11; b = 8'h22; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("no_accept_from_done", 32'(busy), 0);
        repeat (3) @(posedge clk);
        #1;
        check("single_done_pulse", done_cnt, base + 1);
        check("ignored_start_d", 32'(d), 32'(e.d));

        // reset mid-operation aborts without a done pulse
        @(negedge clk);
        a = 8'h55; b = 8'h22; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("d_partial_before_rst", 32'(d != 8'h00), 1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_d", 32'(d), 0);
        check("abort_bout", 32'(bout), 0);
        check("abort_ovf", 32'(ovf), 0);
        base = done_cnt;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check("no_done_after_abort", done_cnt, base);
        run_op(8'h10, 8'h01, 1'b0);

        // start held high: back-to-back operations every 10 cycles
        base = done_cnt;
        done_cyc.delete();
        @(negedge clk);
        a = 8'h40; b = 8'h41; bin = 1'b0; start = 1'b1;
        sb.push_back(model(8'h40, 8'h41, 1'b0));
        @(posedge clk);
        #1 a = 8'h81; b = 8'h02; bin = 1'b1;
        sb.push_back(model(8'h81, 8'h02, 1'b1));
        repeat (10) @(posedge clk);
        #1;
        check("b2b_accept2", 32'(busy), 1);
        a = 8'hC3; b = 8'h3C; bin = 1'b0;
        sb.push_back(model(8'hC3, 8'h3C, 1'b0));
        repeat (10) @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 40 && done_cnt < base + 3; i++) @(posedge clk);
        #1;
        check("b2b_done_count", done_cnt, base + 3);
        if (done_cyc.size() >= 3) begin
            check("b2b_gap1", done_cyc[1] - done_cyc[0], 10);
            check("b2b_gap2", done_cyc[2] - done_cyc[1], 10);
        end
        repeat (3) @(posedge clk);
        check("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, which requests a subtraction; it is sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: the minuend, captured on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: the subtrahend, captured on an accepted start.
REQ-007 The block SHALL have port bin, input, 1 bit: the borrow-in, captured on an accepted start.
REQ-008 The block SHALL have port busy, output, 1 bit, high while in SHIFT or DONE.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking valid results.
REQ-010 The block SHALL have port d, output, WIDTH bits, carrying the difference a - b - bin.
REQ-011 The block SHALL have port bout, output, 1 bit: the final borrow-out, high when unsigned a < b + bin.
REQ-012 The block SHALL have port ovf, output, 1 bit: the two's-complement signed overflow of the difference.

Function
REQ-013 The state machine SHALL have three states, IDLE, SHIFT and DONE, with IDLE as the reset state.
REQ-014 In IDLE with start=1, the block SHALL latch a, b and bin, clear the bit counter, and move to SHIFT on the next edge.
REQ-015 In SHIFT, the block SHALL process one bit per cycle, LSB first.
  - d_i = a_i ^ b_i ^ borrow.
  - borrow' = (~a_i & b_i) | (~(a_i ^ b_i) & borrow).
REQ-016 The borrow flip-flop SHALL be initialised from the latched bin and SHALL carry the borrow between bits.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, after which the block moves to DONE.
REQ-018 DONE SHALL last exactly one cycle.
  - done=1 during that cycle.
  - d, bout and ovf are final.
  - The next state is IDLE.
REQ-019 The latency from the start-accept edge to done high SHALL be WIDTH+1 cycles.
REQ-020 ovf SHALL equal borrow-into-MSB XOR borrow-out-of-MSB.
REQ-021 d, bout and ovf SHALL hold their values after DONE until the next accepted start; they are cleared to 0 on acceptance.
REQ-022 start SHALL be ignored in SHIFT and DONE, with no re-latching and no effect on the operation in progress.
REQ-023 start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE, i.e. back-to-back operations run every WIDTH+2 cycles.
REQ-024 Changes on a, b or bin after acceptance SHALL NOT affect the result.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-026 Asserting rst SHALL force the following immediately, without waiting for clk:
  - state = IDLE;
  - busy=0, done=0;
  - d=0, bout=0, ovf=0;
  - counter, borrow and operand registers all cleared.
REQ-027 rst asserted mid-operation SHALL abort the operation with no done pulse; the first start after rst deasserts is accepted normally.

Structure
REQ-028 The state encoding constants (IDLE=0, SHIFT=1, DONE=2) and the WIDTH default SHALL live in the shared package serial_sub_pkg.
REQ-029 The per-bit logic SHALL be a separate combinational sub-module, fullsubtractor1, with ports (x, y, bi, d, bo), instantiated once.
REQ-030 Operands SHALL be held in right-shifting registers; d SHALL be assembled by shifting into its MSB.

Verification (WIDTH=8)
REQ-031 Scenario: a=0x05, b=0x03, bin=0 -> done exactly 9 cycles after accept; d=0x02, bout=0, ovf=0.
REQ-032 Scenario: a=0x03, b=0x05, bin=0 -> d=0xFE, bout=1, ovf=0; a=0x00, b=0x00, bin=1 -> d=0xFF, bout=1, ovf=0.
REQ-033 Scenario: a=0x80, b=0x01 -> d=0x7F, bout=0, ovf=1; a=0x7F, b=0xFF -> d=0x80, bout=1, ovf=1.
REQ-034 Scenario: pulse start with new operands during SHIFT and during DONE -> results of the first operation are unchanged; exactly one done pulse.
REQ-035 Scenario: assert rst 4 cycles into SHIFT -> busy, d, bout and ovf go 0 before the next edge; no done pulse; a following start with a=0x10, b=0x01 gives d=0x0F.
REQ-036 Scenario: start held high for 3 operations -> done pulses 10 cycles apart; each result matches its own operands.
